// File: rtl/cla_pipe_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : cla_pipe_adder_if
// Purpose  : Valid/ready operand and result bundle for cla_pipe_adder.
// Revision : 1.0 - initial release
// ============================================================================
interface cla_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, result, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, result, cout, ovf, zero
  );
endinterface
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_pipe_adder
// Purpose  : Pipelined carry-lookahead add/sub, one CHUNK-bit group per stage.
// Revision : 1.0 - initial release
// ============================================================================
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  cla_pipe_adder_if.slave bus
);
  localparam int NSTG = WIDTH / CHUNK;

  // Flat sum-of-products lookahead: every carry is two gate levels from g/p/c0.
  function automatic logic [CHUNK:0] f_carries(input logic [CHUNK-1:0] g,
                                               input logic [CHUNK-1:0] p,
                                               input logic             c0);
    logic [CHUNK:0] c;
    logic           term;
    c[0] = c0;
    for (int i = 1; i <= CHUNK; i++) begin
      c[i] = 1'b0;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
      term = c0;
      for (int m = 0; m < i; m++) term = term & p[m];
      c[i] = c[i] | term;
    end
    return c;
  endfunction

  logic [NSTG-1:0]  valid_q;
  logic [WIDTH-1:0] a_q   [NSTG];
  logic [WIDTH-1:0] b_q   [NSTG];
  logic [WIDTH-1:0] sum_q [NSTG];
  logic [NSTG-1:0]  c_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [WIDTH-1:0] w_sum [NSTG];
  logic [NSTG-1:0]  w_cout;
  logic             w_ctop;
  logic             w_advance;
  logic             w_accept;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_eff;

  logic [WIDTH-1:0] result_d;
  logic             cout_d;
  logic             ovf_d;
  logic             zero_d;

  assign w_advance = ~out_valid_q | bus.out_ready;
  assign w_accept  = bus.in_valid & w_advance;

  // op[0] selects inversion of B; op[1] selects external carry over the implicit one.
  assign w_b_eff = bus.op[0] ? ~bus.b : bus.b;
  assign w_c_eff = bus.op[1] ? bus.cin : bus.op[0];

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic [CHUNK:0]   w_c;

    assign w_ca      = a_q[k][k*CHUNK +: CHUNK];
    assign w_cb      = b_q[k][k*CHUNK +: CHUNK];
    assign w_c       = f_carries(w_ca & w_cb, w_ca | w_cb, c_q[k]);
    assign w_sum[k]  = sum_q[k] | (WIDTH'(w_ca ^ w_cb ^ w_c[CHUNK-1:0]) << (k * CHUNK));
    assign w_cout[k] = w_c[CHUNK];

    if (k == NSTG - 1) begin : g_last
      assign w_ctop = w_c[CHUNK-1];
    end
  end

  assign result_d = w_sum[NSTG-1];
  assign cout_d   = w_cout[NSTG-1];
  assign ovf_d    = w_ctop ^ w_cout[NSTG-1];
  assign zero_d   = ~|w_sum[NSTG-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (w_advance) begin
      valid_q[0] <= w_accept;
      for (int i = 1; i < NSTG; i++) valid_q[i] <= valid_q[i-1];
      out_valid_q <= valid_q[NSTG-1];
      if (valid_q[NSTG-1]) begin
        result_q <= result_d;
        cout_q   <= cout_d;
        ovf_q    <= ovf_d;
        zero_q   <= zero_d;
      end
    end
  end

  // Payload carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clock) begin
    if (w_advance) begin
      if (w_accept) begin
        a_q[0]   <= bus.a;
        b_q[0]   <= w_b_eff;
        c_q[0]   <= w_c_eff;
        sum_q[0] <= '0;
      end
      for (int i = 1; i < NSTG; i++) begin
        a_q[i]   <= a_q[i-1];
        b_q[i]   <= b_q[i-1];
        c_q[i]   <= w_cout[i-1];
        sum_q[i] <= w_sum[i-1];
      end
    end
  end

  assign bus.in_ready  = w_advance;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule
`default_nettype wire

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead add/subtract unit for the processor datapath. Splits a WIDTH-bit operation into WIDTH/CHUNK lookahead groups and resolves one group per pipeline stage. Accepts one operation per cycle under a valid/ready handshake with full backpressure. Produces sum, carry-out, signed overflow and zero flags. Replaces the fixed 8-bit combinational lookahead adder wherever wider operands or carry-in/subtract modes are needed.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 8, bits resolved per stage; each group uses full 2-level lookahead, not ripple.
- Derived: NSTG = WIDTH/CHUNK, which is the pipeline depth.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  stage 0 can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry/borrow-in; used by ADC and SBB only.
- op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBB.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum or difference.
- cout  out  1  carry out of bit WIDTH-1; for SUB/SBB, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  result == 0.

## Operation
- Effective B and carry-in, fixed at acceptance:
  - ADD: B, 0.
  - SUB: ~B, 1.
  - ADC: B, cin.
  - SBB: ~B, cin.
- Stage k (0..NSTG-1) holds:
  - the effective operands;
  - the carry into chunk k;
  - the result bits of chunks 0..k-1;
  - a valid bit.
- Each stage computes chunk k with lookahead: per-bit g = a&b, p = a|b; the sum bit is a^b^c. It produces the chunk's sum bits and its carry into chunk k+1, then passes all of it down the pipe.
- Upper operand chunks travel with the operation and are not sampled again, so input ports may change after acceptance.
- Last stage registers the outputs:
  - result;
  - cout = carry out of the top chunk;
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1;
  - zero = ~|result.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Flow control is a global stall: advance = ~out_valid | out_ready.
  - When advance=1, every stage shifts one position and stage 0 loads the input if in_valid & in_ready.
  - in_ready = advance; it is combinational from out_valid and out_ready.
  - Bubbles (valid=0) propagate normally. Bubbles are not compressed.
- An accepted operation is never dropped or duplicated. Results leave in acceptance order.
- Reset, asynchronous, may occur mid-operation:
  - all valid bits clear immediately;
  - out_valid=0, result=0, cout=0, ovf=0, zero=0;
  - in-flight operations are discarded.
  - Data registers other than the outputs need not reset.

## Timing
- Latency: an operation accepted at edge t presents out_valid=1 with its result after edge t+NSTG, provided there is no stall.
- Throughput: one operation per cycle while out_ready=1.
- While out_valid=1 and out_ready=0:
  - result, cout, ovf and zero are held stable;
  - in_ready=0;
  - no stage changes.
- The handshake completes on any edge where out_valid & out_ready.
  - On that same edge a new result may load, giving back-to-back results.
- in_ready does not depend on in_valid.
- After reset deassertion, in_ready=1 in the first cycle.

## Test plan
- Basic ADD, WIDTH=32, CHUNK=8: a=0x0000_00FF, b=0x0000_0001, ADD.
  - Required: after 4 cycles, result=0x0000_0100, cout=0, ovf=0, zero=0.
- Full carry chain across all chunks: a=0xFFFF_FFFF, b=0x0000_0001, ADD.
  - Required: result=0x0000_0000, cout=1, ovf=0, zero=1.
  - Same operands with ADC and cin=1: result=0x0000_0001, cout=1.
- Subtract and overflow:
  - SUB a=0x8000_0000, b=1: result=0x7FFF_FFFF, cout=1, ovf=1.
  - SUB a=5, b=7: result=0xFFFF_FFFE, cout=0, ovf=0.
  - SBB a=5, b=5, cin=0: result=0xFFFF_FFFF, cout=0.
- Streaming with backpressure: issue 10 random operations back-to-back while out_ready toggles pseudo-randomly.
  - Required: results emerge in order and match a reference model.
  - Outputs stay stable while stalled.
  - in_ready tracks ~out_valid | out_ready every cycle.
- Mid-flight reset: issue 3 operations, then pulse reset_n low for a half cycle, asynchronously between edges.
  - Required: outputs go to 0 and out_valid=0 immediately.
  - No stale result ever appears.
  - The next operation completes with normal latency.
- Parameter sweep, using the ADD/SUB cases above rescaled to each width:
  - WIDTH=16, CHUNK=8: latency 2.
  - WIDTH=8, CHUNK=8: latency 1; 0x7F+0x01 gives result=0x80, ovf=1.
